sdrc_bank_req_q: RTL and testbench
==================================

# sdrc_bank_req_q

Request queue at the bank-control end of the request-generator handshake. Accepts chunked SDRAM requests (`r2b_*`), answers with a one-cycle `b2r_ack`, and advertises `b2r_arb_ok` only when a whole page-split request (two chunks) is guaranteed to fit. Buffers chunks in order in a DEPTH-entry FIFO and presents the head to the bank FSM through a valid/ready handshake.

## Interface
- `SDR_REQ_ID_W`, default 4: request ID width.
- `REQ_BW`, default 12: chunk length width.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `AW`, default 2: log2(DEPTH).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `r2b_req` in 1: chunk valid.
- `r2b_req_id` in SDR_REQ_ID_W: request ID.
- `r2b_start` in 1: first chunk of a request.
- `r2b_last` in 1: last chunk of a request.
- `r2b_wrap` in 1: wrap mode.
- `r2b_write` in 1: 1 = write, 0 = read.
- `r2b_ba` in 2: bank address.
- `r2b_raddr` in 12: row address.
- `r2b_caddr` in 12: column address.
- `r2b_len` in REQ_BW: chunk length.
- `b2r_ack` out 1: chunk accepted this cycle.
- `b2r_arb_ok` out 1: at least 2 free entries.
- `q_valid` out 1: head entry valid.
- `q_ready` in 1: consumer takes the head.
- `q_req_id`, `q_start`, `q_last`, `q_wrap`, `q_write`, `q_ba`, `q_raddr`, `q_caddr`, `q_len` out (same widths as the `r2b_*` fields): head entry fields.
- `q_count` out AW+1: occupancy.

## Operation
- Internal signals:
  - `pop` = `q_valid & q_ready`.
  - `full` = (`count` == DEPTH).
  - `push` = `b2r_ack`.
- `b2r_ack` is combinational: `b2r_ack` = `r2b_req & (~full | pop)`. It is never high while `r2b_req` is low.
- On push, all nine `r2b_*` fields are written as one entry at `wr_ptr`, and `wr_ptr` increments.
- On pop, `rd_ptr` increments.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- Count update: `count` += push − pop. Simultaneous push and pop leaves `count` unchanged, including when full or when empty.
- Empty plus simultaneous push: there is no bypass. The entry appears on `q_*` the next cycle.
- `b2r_arb_ok` is combinational from registered `count`: `b2r_arb_ok` = (`count` ≤ DEPTH−2). It ignores a same-cycle pop.
- Head outputs are a combinational read of `mem[rd_ptr]`. `q_valid` = (`count` != 0). `q_count` = `count`.
- Order is strictly FIFO. Fields are stored and returned unmodified, with no length or address arithmetic.
- Storage contents are don't-care while `q_valid` = 0, except after reset, where they are zero.
- The producer may present back-to-back chunks; each cycle with `r2b_req` & `b2r_ack` is exactly one entry.

## Timing
- Reset (asynchronous, takes effect immediately; state is held while `reset_n` = 0):
  - pointers and `count` = 0; storage = 0.
  - `q_valid` = 0, `q_count` = 0, all `q_*` fields = 0.
  - `b2r_arb_ok` = 1; `b2r_ack` = 0 unless `r2b_req` is high.
- Reset asserted mid-operation discards all entries. An ack given in the reset cycle is lost.
- Latency: a chunk acked at edge N is visible on `q_*` with `q_valid` = 1 after edge N. Minimum 1 cycle.
- Throughput: 1 push and 1 pop per cycle.
- Full with `q_ready` = 0: `b2r_ack` = 0 and `r2b_req` is held by the producer.

## Test plan
- Single chunk with `q_ready` = 0:
  - Stimulus: `r2b_req` = 1, ba=2, raddr=0x123, caddr=0x0F0, len=16, start=1, last=1, write=1, id=5.
  - Response: `b2r_ack` = 1 in the same cycle; next cycle `q_valid` = 1 with identical fields, `q_count` = 1, `b2r_arb_ok` = 1.
- Page-split pair:
  - Stimulus: two consecutive cycles of `r2b_req` = 1, chunk A (caddr=0xF8, len=8, start=1, last=0) then chunk B (caddr=0x000, len=8, start=0, last=1), `q_ready` = 0.
  - Response: two consecutive acks; `q_count` = 2; `b2r_arb_ok` = 1 with DEPTH = 4; pops return A then B.
- Fill with `q_ready` = 0, DEPTH = 4:
  - `b2r_arb_ok` falls once `q_count` = 3.
  - The 5th `r2b_req` gets `b2r_ack` = 0 until `q_ready` = 1; in that cycle ack = 1 and `q_count` stays at 4.
- Pointer wrap:
  - Stimulus: 10 chunks with id 0..9, `q_ready` = 1 throughout.
  - Response: output ids 0..9 in order, each one cycle after its ack; `q_count` ≤ 1.
- Reset mid-stream:
  - Stimulus: drop `reset_n` with 3 entries queued.
  - Response: `q_valid` = 0 and `q_count` = 0 immediately, `b2r_arb_ok` = 1; after release, the next chunk is queued normally.

Source files
------------

// File: rtl/sdrc_bank_req_q.sv
`default_nettype none
// ============================================================================
//  Module   : sdrc_bank_req_q
//  Brief    : In-order chunk queue between request generator and bank FSM;
//             arb_ok advertises room for a full two-chunk page-split request.
//  Revision : 1.0  initial release
// ============================================================================
module sdrc_bank_req_q #(
    parameter int SDR_REQ_ID_W = 4,
    parameter int REQ_BW       = 12,
    parameter int DEPTH        = 4,
    parameter int AW           = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    r2b_req,
    input  logic [SDR_REQ_ID_W-1:0] r2b_req_id,
    input  logic                    r2b_start,
    input  logic                    r2b_last,
    input  logic                    r2b_wrap,
    input  logic                    r2b_write,
    input  logic [1:0]              r2b_ba,
    input  logic [11:0]             r2b_raddr,
    input  logic [11:0]             r2b_caddr,
    input  logic [REQ_BW-1:0]       r2b_len,
    output logic                    b2r_ack,
    output logic                    b2r_arb_ok,
    output logic                    q_valid,
    input  logic                    q_ready,
    output logic [SDR_REQ_ID_W-1:0] q_req_id,
    output logic                    q_start,
    output logic                    q_last,
    output logic                    q_wrap,
    output logic                    q_write,
    output logic [1:0]              q_ba,
    output logic [11:0]             q_raddr,
    output logic [11:0]             q_caddr,
    output logic [REQ_BW-1:0]       q_len,
    output logic [AW:0]             q_count
);

    localparam int            C_EW       = SDR_REQ_ID_W + 4 + 2 + 12 + 12 + REQ_BW;
    localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   C_ARB_MAX  = (AW + 1)'(DEPTH - 2);

    logic [C_EW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [C_EW-1:0] w_wr_entry;
    logic [C_EW-1:0] w_head;
    logic [AW:0]     w_count_nxt;

    assign w_full  = (r_count == C_DEPTH);
    assign q_valid = (r_count != '0);
    assign w_pop   = q_valid & q_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign b2r_ack = r2b_req & (~w_full | w_pop);
    assign w_push  = b2r_ack;

    assign b2r_arb_ok = (r_count <= C_ARB_MAX);
    assign q_count    = r_count;

    assign w_wr_entry = {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
                         r2b_ba, r2b_raddr, r2b_caddr, r2b_len};

    assign w_head = r_mem[r_rd_ptr];
    assign {q_req_id, q_start, q_last, q_wrap, q_write,
            q_ba, q_raddr, q_caddr, q_len} = w_head;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // Storage is cleared on reset so the head reads as zero until first push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdrc_bank_req_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdrc_bank_req_q
//  Brief    : Vector table, directed corner sequences and random traffic
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdrc_bank_req_q;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  id;
        logic        start;
        logic        last;
        logic        wrap;
        logic        write;
        logic [1:0]  ba;
        logic [11:0] raddr;
        logic [11:0] caddr;
        logic [11:0] len;
    } chunk_t;

    typedef struct {
        logic   req;
        chunk_t c;
        logic   rdy;
        logic   exp_ack;
        logic   exp_arb;
        logic   exp_valid;
        int     exp_count;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        r2b_req;
    chunk_t      din;
    logic        b2r_ack;
    logic        b2r_arb_ok;
    logic        q_valid;
    logic        q_ready;
    chunk_t      dout;
    logic [2:0]  q_count;

    int checks;
    int errors;
    chunk_t mq[$];
    logic   exp_ack_r;

    sdrc_bank_req_q #(
        .SDR_REQ_ID_W(4), .REQ_BW(12), .DEPTH(DEPTH), .AW(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .r2b_req    (r2b_req),
        .r2b_req_id (din.id),
        .r2b_start  (din.start),
        .r2b_last   (din.last),
        .r2b_wrap   (din.wrap),
        .r2b_write  (din.write),
        .r2b_ba     (din.ba),
        .r2b_raddr  (din.raddr),
        .r2b_caddr  (din.caddr),
        .r2b_len    (din.len),
        .b2r_ack    (b2r_ack),
        .b2r_arb_ok (b2r_arb_ok),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_req_id   (dout.id),
        .q_start    (dout.start),
        .q_last     (dout.last),
        .q_wrap     (dout.wrap),
        .q_write    (dout.write),
        .q_ba       (dout.ba),
        .q_raddr    (dout.raddr),
        .q_caddr    (dout.caddr),
        .q_len      (dout.len),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic chunk_t mk(input int id, input int ba, input int ra, input int ca,
                                  input int len, input bit st, input bit la, input bit wr);
        chunk_t c;
        c.id = 4'(id); c.start = st; c.last = la; c.wrap = 1'b0; c.write = wr;
        c.ba = 2'(ba); c.raddr = 12'(ra); c.caddr = 12'(ca); c.len = 12'(len);
        return c;
    endfunction

    // Drive inputs, then compare against the model mid-cycle.
    task automatic drive_check(input logic req, input chunk_t c, input logic rdy);
        r2b_req = req; din = c; q_ready = rdy;
        @(negedge clk);
        exp_ack_r = req && ((mq.size() < DEPTH) || (mq.size() > 0 && rdy));
        chk("ack", 64'(b2r_ack), 64'(exp_ack_r));
        chk("arb_ok", 64'(b2r_arb_ok), 64'(mq.size() <= DEPTH - 2));
        chk("valid", 64'(q_valid), 64'(mq.size() != 0));
        chk("count", 64'(q_count), 64'(mq.size()));
        if (mq.size() != 0) chk("head", 64'(dout), 64'(mq[0]));
    endtask

    task automatic advance(input chunk_t c, input logic rdy);
        @(posedge clk);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (exp_ack_r) mq.push_back(c);
        #1;
    endtask

    task automatic cycle(input logic req, input chunk_t c, input logic rdy);
        drive_check(req, c, rdy);
        advance(c, rdy);
    endtask

    vec_t vt[12];
    chunk_t cs, ca, cb, cc, cd;

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; r2b_req = 1'b0; din = '0; q_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(q_valid), 64'd0);
        chk("rst_count", 64'(q_count), 64'd0);
        chk("rst_arb", 64'(b2r_arb_ok), 64'd1);
        chk("rst_head", 64'(dout), 64'd0);
        chk("rst_ack", 64'(b2r_ack), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        cs = mk(5, 2, 'h123, 'h0F0, 16, 1, 1, 1);
        ca = mk(1, 1, 'h050, 'h0F8, 8, 1, 0, 0);
        cb = mk(1, 1, 'h051, 'h000, 8, 0, 1, 0);
        cc = mk(2, 3, 'hABC, 'h010, 4, 1, 1, 1);
        cd = mk(3, 0, 'hFFF, 'hFFF, 'hFFF, 1, 1, 0);
        //           req  chunk rdy  ack  arb  vld  cnt
        vt[0]  = '{1'b1, cs, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vt[1]  = '{1'b0, cs, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[2]  = '{1'b1, ca, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        vt[3]  = '{1'b1, cb, 1'b0, 1'b1, 1'b1, 1'b1, 2};
        vt[4]  = '{1'b1, cc, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vt[5]  = '{1'b1, cd, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        vt[6]  = '{1'b1, cd, 1'b1, 1'b1, 1'b0, 1'b1, 4};
        vt[7]  = '{1'b0, cd, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vt[8]  = '{1'b0, cd, 1'b1, 1'b0, 1'b0, 1'b1, 3};
        vt[9]  = '{1'b0, cd, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        vt[10] = '{1'b0, cd, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        vt[11] = '{1'b0, cd, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            drive_check(vt[i].req, vt[i].c, vt[i].rdy);
            chk("tbl_ack", 64'(b2r_ack), 64'(vt[i].exp_ack));
            chk("tbl_arb", 64'(b2r_arb_ok), 64'(vt[i].exp_arb));
            chk("tbl_valid", 64'(q_valid), 64'(vt[i].exp_valid));
            chk("tbl_count", 64'(q_count), 64'(vt[i].exp_count));
            if (i == 1) chk("tbl_single", 64'(dout), 64'(cs));
            if (i == 7) chk("tbl_pop_a", 64'(dout), 64'(ca));
            if (i == 8) chk("tbl_pop_b", 64'(dout), 64'(cb));
            advance(vt[i].c, vt[i].rdy);
        end

        // Pointer wrap: ids 0..9 stream through with ready held high.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, mk(i, i % 4, i * 3, i * 5, i + 1, 1, 1, i[0]), 1'b1);
            chk("wrap_head_id", 64'(dout.id), 64'(i));
            chk("wrap_count_le1", 64'(q_count <= 3'd1), 64'd1);
        end
        cycle(1'b0, '0, 1'b1);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(8 + i, 1, 7, 9, 2, 1, 0, 1), 1'b0);
        r2b_req = 1'b0;
        reset_n = 1'b0;
        #1;
        mq.delete();
        chk("midrst_valid", 64'(q_valid), 64'd0);
        chk("midrst_count", 64'(q_count), 64'd0);
        chk("midrst_arb", 64'(b2r_arb_ok), 64'd1);
        chk("midrst_head", 64'(dout), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, cc, 1'b0);
        chk("postrst_head", 64'(dout), 64'(cc));
        chk("postrst_count", 64'(q_count), 64'd1);
        cycle(1'b0, '0, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            logic [63:0] rv;
            rv = {$urandom(), $urandom()};
            cycle(($urandom_range(0, 9) < 7), chunk_t'(rv[47:0]), ($urandom_range(0, 9) < 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
